// File: rtl/count_ascii_sender.sv
// Streams a saturated 0..9999 count as ASCII "dddd\r\n" over the UART TX start/busy handshake.
// Latency: first tx_start CNT_W+1 clocks after request; backpressure via tx_busy, one byte per frame.
module count_ascii_sender #(
  parameter int CNT_W     = 14,
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send_req,
  input  logic [CNT_W-1:0] count_in,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, CONV, SEND, WAIT_HI, WAIT_LO, DONE} state_t;

  localparam int         SH_W     = $clog2(CNT_W + 1);
  localparam logic [2:0] LAST_IDX = SEND_CRLF ? 3'd5 : 3'd3;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bin;
  logic [15:0]      bcd;
  logic [15:0]      bcd_adj;
  logic [SH_W-1:0]  shift_cnt;
  logic [2:0]       idx;
  logic [CNT_W-1:0] sat_val;
  logic [7:0]       byte_sel;
  logic             last_shift;

  always_comb begin
    sat_val = count_in;
    if (32'(count_in) > 32'd9999) sat_val = CNT_W'(9999);
  end

  // Double-dabble correction: any nibble >= 5 would overflow past 9 after the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign last_shift = (shift_cnt == SH_W'(CNT_W - 1));

  always_comb begin
    byte_sel = 8'h00;
    case (idx)
      3'd0:    byte_sel = 8'h30 + {4'h0, bcd[15:12]};
      3'd1:    byte_sel = 8'h30 + {4'h0, bcd[11:8]};
      3'd2:    byte_sel = 8'h30 + {4'h0, bcd[7:4]};
      3'd3:    byte_sel = 8'h30 + {4'h0, bcd[3:0]};
      3'd4:    byte_sel = 8'h0D;
      3'd5:    byte_sel = 8'h0A;
      default: byte_sel = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (send_req) state_nxt = CONV;
      CONV:    if (last_shift) state_nxt = SEND;
      SEND:    state_nxt = WAIT_HI;
      WAIT_HI: if (tx_busy) state_nxt = WAIT_LO;
      WAIT_LO: if (!tx_busy) state_nxt = (idx == LAST_IDX) ? DONE : SEND;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin       <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
      idx       <= '0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (send_req) begin
            bin       <= sat_val;
            bcd       <= '0;
            shift_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        CONV: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          shift_cnt  <= shift_cnt + SH_W'(1);
          if (last_shift) idx <= '0;
        end
        SEND: begin
          tx_data  <= byte_sel;
          tx_start <= 1'b1;
        end
        WAIT_LO: begin
          if (!tx_busy && idx != LAST_IDX) idx <= idx + 3'd1;
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_count_ascii_sender.sv
// Directed bench for count_ascii_sender with a simple UART TX busy model.
module tb_count_ascii_sender;

  logic        clk;
  logic        rst;
  logic        send_req, send_req2;
  logic [13:0] count_in, count_in2;
  logic        tx_busy, tx_busy2;
  logic        tx_start, tx_start2;
  logic [7:0]  tx_data, tx_data2;
  logic        busy, busy2;
  logic        done, done2;

  int vectors = 0;
  int miscompares = 0;

  // UART TX model: busy rises 2 clocks after tx_start, stays high frame_len clocks
  logic model_en;
  logic man_busy;
  logic m_busy;
  int   m_wait, m_frame;
  int   frame_len;

  logic [7:0] bytes[$];
  int         done_cnt;
  int         start_viol;

  assign tx_busy = model_en ? m_busy : man_busy;

  count_ascii_sender #(.CNT_W(14), .SEND_CRLF(1'b1)) dut (
    .clk(clk), .rst(rst), .send_req(send_req), .count_in(count_in), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .done(done)
  );

  count_ascii_sender #(.CNT_W(14), .SEND_CRLF(1'b0)) dut2 (
    .clk(clk), .rst(rst), .send_req(send_req2), .count_in(count_in2), .tx_busy(tx_busy2),
    .tx_start(tx_start2), .tx_data(tx_data2), .busy(busy2), .done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      m_wait = 0; m_frame = 0; m_busy = 1'b0;
    end else if (m_frame > 0) begin
      m_frame--;
      if (m_frame == 0) m_busy = 1'b0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin m_busy = 1'b1; m_frame = frame_len; end
    end else if (tx_start && model_en) begin
      m_wait = 2;
    end
  end

  always @(negedge clk) begin
    if (!rst && tx_start) begin
      bytes.push_back(tx_data);
      if (tx_busy) start_viol++;
    end
    if (!rst && done) done_cnt++;
  end

  function automatic logic [47:0] pack6();
    logic [47:0] r = '0;
    for (int i = 0; i < bytes.size() && i < 6; i++) r = {r[39:0], bytes[i]};
    return r;
  endfunction

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic send_and_wait(input logic [13:0] val, output bit ok);
    bytes.delete(); done_cnt = 0; start_viol = 0;
    count_in = val; send_req = 1'b1;
    @(posedge clk); #2; send_req = 1'b0;
    wait_done(ok);
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_tx_start got=%b want=0", tx_start); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b want=0", done); end
    repeat (3) @(posedge clk);
    #2; rst = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_basic_1234();
    int lat = 0;
    bit ok;
    bytes.delete(); done_cnt = 0; start_viol = 0;
    count_in = 14'd1234; send_req = 1'b1;
    @(posedge clk); #2; send_req = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_on_accept got=%b want=1", busy); end
    while (!tx_start && lat < 100) begin @(posedge clk); #2; lat++; end
    vectors++; if (lat !== 15) begin miscompares++; $display("FAIL basic_first_start_latency got=%0d want=15", lat); end
    wait_done(ok);
    @(posedge clk); #2;
    vectors++; if (!ok) begin miscompares++; $display("FAIL basic_done_timeout got=0 want=1"); end
    vectors++; if (pack6() !== 48'h313233340D0A) begin miscompares++; $display("FAIL basic_bytes got=%h want=313233340d0a", pack6()); end
    vectors++; if (bytes.size() !== 6) begin miscompares++; $display("FAIL basic_start_count got=%0d want=6", bytes.size()); end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL basic_done_count got=%0d want=1", done_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    vectors++; if (start_viol !== 0) begin miscompares++; $display("FAIL basic_start_while_busy got=%0d want=0", start_viol); end
  endtask

  task automatic test_values();
    logic [13:0] vals [3];
    logic [47:0] exps [3];
    bit ok;
    vals = '{14'd0, 14'd9999, 14'd12000};
    exps = '{48'h303030300D0A, 48'h393939390D0A, 48'h393939390D0A};
    for (int k = 0; k < 3; k++) begin
      send_and_wait(vals[k], ok);
      vectors++; if (!ok || pack6() !== exps[k] || bytes.size() !== 6)
        begin miscompares++; $display("FAIL value_%0d got=%h n=%0d want=%h n=6", vals[k], pack6(), bytes.size(), exps[k]); end
    end
  endtask

  task automatic test_ignore_req();
    bit ok;
    int t = 0;
    bytes.delete(); done_cnt = 0;
    count_in = 14'd1234; send_req = 1'b1;
    @(posedge clk); #2; send_req = 1'b0;
    while (bytes.size() < 3 && t < 1000) begin @(posedge clk); #2; t++; end
    count_in = 14'd5678; send_req = 1'b1;
    @(posedge clk); #2; send_req = 1'b0;
    wait_done(ok);
    repeat (60) @(posedge clk);
    #2;
    vectors++; if (!ok || pack6() !== 48'h313233340D0A) begin miscompares++; $display("FAIL ignore_req_bytes got=%h want=313233340d0a", pack6()); end
    vectors++; if (bytes.size() !== 6 || done_cnt !== 1 || busy !== 1'b0)
      begin miscompares++; $display("FAIL ignore_req_extra got starts=%0d dones=%0d busy=%b want 6/1/0", bytes.size(), done_cnt, busy); end
  endtask

  task automatic test_long_busy();
    bit ok;
    int t = 0;
    int bad = 0;
    frame_len = 500;
    bytes.delete(); done_cnt = 0;
    count_in = 14'd1234; send_req = 1'b1;
    @(posedge clk); #2; send_req = 1'b0;
    while (!tx_busy && t < 100) begin @(posedge clk); #2; t++; end
    frame_len = 40;
    t = 0;
    while (tx_busy && t < 1000) begin
      if (tx_start !== 1'b0 || tx_data !== 8'h31) bad++;
      @(posedge clk); #2; t++;
    end
    vectors++; if (bad !== 0 || bytes.size() !== 1 || t < 490)
      begin miscompares++; $display("FAIL long_busy_hold got bad=%0d starts=%0d held=%0d want 0/1/>=490", bad, bytes.size(), t); end
    @(posedge clk); #2;
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL long_busy_early_start got=%b want=0", tx_start); end
    @(posedge clk); #2;
    vectors++; if (tx_start !== 1'b1 || tx_data !== 8'h32)
      begin miscompares++; $display("FAIL long_busy_next_start got=%b/%h want=1/32", tx_start, tx_data); end
    wait_done(ok);
    @(posedge clk); #2;
    vectors++; if (!ok || pack6() !== 48'h313233340D0A) begin miscompares++; $display("FAIL long_busy_bytes got=%h want=313233340d0a", pack6()); end
  endtask

  task automatic test_busy_already_high();
    bit ok;
    int t = 0;
    model_en = 1'b0; man_busy = 1'b1;
    bytes.delete(); done_cnt = 0;
    count_in = 14'd1234; send_req = 1'b1;
    @(posedge clk); #2; send_req = 1'b0;
    while (!tx_start && t < 100) begin @(posedge clk); #2; t++; end
    vectors++; if (tx_data !== 8'h31) begin miscompares++; $display("FAIL prebusy_first_byte got=%h want=31", tx_data); end
    repeat (10) @(posedge clk);
    #2;
    vectors++; if (bytes.size() !== 1) begin miscompares++; $display("FAIL prebusy_extra_start got=%0d want=1", bytes.size()); end
    model_en = 1'b1; man_busy = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    vectors++; if (tx_start !== 1'b1 || tx_data !== 8'h32)
      begin miscompares++; $display("FAIL prebusy_second_start got=%b/%h want=1/32", tx_start, tx_data); end
    wait_done(ok);
    @(posedge clk); #2;
    vectors++; if (!ok || pack6() !== 48'h313233340D0A || bytes.size() !== 6)
      begin miscompares++; $display("FAIL prebusy_bytes got=%h n=%0d want=313233340d0a n=6", pack6(), bytes.size()); end
  endtask

  task automatic test_rst_mid();
    bit ok;
    int t = 0;
    bytes.delete(); done_cnt = 0;
    count_in = 14'd1234; send_req = 1'b1;
    @(posedge clk); #2; send_req = 1'b0;
    while (!(bytes.size() == 4 && tx_busy) && t < 1000) begin @(posedge clk); #2; t++; end
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (tx_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00)
      begin miscompares++; $display("FAIL rst_mid got start=%b busy=%b done=%b data=%h want 0/0/0/00", tx_start, busy, done, tx_data); end
    repeat (3) @(posedge clk);
    #2; rst = 1'b0;
    @(posedge clk); #2;
    send_and_wait(14'd42, ok);
    vectors++; if (!ok || pack6() !== 48'h303034320D0A || bytes.size() !== 6)
      begin miscompares++; $display("FAIL rst_then_42 got=%h n=%0d want=303034320d0a n=6", pack6(), bytes.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bytes.delete(); done_cnt = 0;
    count_in = 14'd77; send_req = 1'b1;
    wait_done(ok);
    @(posedge clk); #2;
    vectors++; if (!ok || pack6() !== 48'h303037370D0A || busy !== 1'b1)
      begin miscompares++; $display("FAIL b2b_first got=%h busy=%b want=303037370d0a busy=1", pack6(), busy); end
    send_req = 1'b0;
    bytes.delete();
    wait_done(ok);
    @(posedge clk); #2;
    vectors++; if (!ok || pack6() !== 48'h303037370D0A || bytes.size() !== 6 || done_cnt !== 2)
      begin miscompares++; $display("FAIL b2b_second got=%h n=%0d dones=%0d want=303037370d0a n=6 dones=2", pack6(), bytes.size(), done_cnt); end
  endtask

  task automatic test_no_crlf();
    logic [31:0] got = '0;
    int n = 0;
    int t;
    bit ok = 1'b0;
    count_in2 = 14'd7; send_req2 = 1'b1;
    @(posedge clk); #2; send_req2 = 1'b0;
    for (int b = 0; b < 5; b++) begin
      t = 0;
      while (!tx_start2 && !done2 && t < 60) begin @(posedge clk); #2; t++; end
      if (done2) begin ok = 1'b1; break; end
      if (!tx_start2) break;
      got = {got[23:0], tx_data2}; n++;
      @(posedge clk); #2; tx_busy2 = 1'b1;
      repeat (5) @(posedge clk);
      #2; tx_busy2 = 1'b0;
    end
    vectors++; if (got !== 32'h30303037 || n !== 4) begin miscompares++; $display("FAIL nocrlf_bytes got=%h n=%0d want=30303037 n=4", got, n); end
    vectors++; if (!ok) begin miscompares++; $display("FAIL nocrlf_done got=0 want=1"); end
    @(posedge clk); #2;
    vectors++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin miscompares++; $display("FAIL nocrlf_idle got done=%b busy=%b want 0/0", done2, busy2); end
  endtask

  initial begin
    rst = 1'b1; send_req = 1'b0; send_req2 = 1'b0;
    count_in = '0; count_in2 = '0; tx_busy2 = 1'b0;
    model_en = 1'b1; man_busy = 1'b0; frame_len = 40;
    done_cnt = 0; start_viol = 0;
    test_reset();
    test_basic_1234();
    test_values();
    test_ignore_req();
    test_long_busy();
    test_busy_already_high();
    test_rst_mid();
    test_back_to_back();
    test_no_crlf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/count_ascii_sender.md
Name: count_ascii_sender

Overview:
Converts a binary counter value (0..9999) into a 6-byte ASCII record: four decimal digits with leading zeros, then CR and LF. It feeds the byte-serial UART transmitter, one byte per frame, through that transmitter's tx_start/tx_data/tx_busy handshake. The block sits between the counter datapath and the UART TX, so the count can be streamed to a host terminal on request.

Parameters:
CNT_W, 14, width of count_in; value range 0..2^CNT_W-1, inputs above 9999 saturate to 9999
SEND_CRLF, 1, 1 = append 0x0D 0x0A after the digits; 0 = send 4 digits only

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
send_req  input  1  request to send the current count_in; sampled only in IDLE
count_in  input  CNT_W  binary count value
tx_busy  input  1  from UART TX; high while a frame is in flight
tx_start  output  1  one-cycle pulse to UART TX to start a frame
tx_data  output  8  byte for UART TX; stable from the tx_start cycle until the next byte loads
busy  output  1  high from request acceptance until the record finishes
done  output  1  one-cycle pulse when the last byte's frame completes

Behaviour:
- Reset (async, rst=1): state=IDLE, tx_start=0, tx_data=8'h00, busy=0, done=0, BCD/shift/byte index cleared. All outputs are registered.
- States: IDLE, CONV, SEND, WAIT_HI, WAIT_LO, DONE.
- IDLE:
  - On the edge E0 that samples send_req=1: latch min(count_in, 9999) and go to CONV.
  - busy=1 from E0.
  - send_req while not in IDLE is ignored; requests are not queued.
- CONV: double-dabble conversion.
  - One shift per clock for exactly CNT_W clocks (edges E1..E_CNT_W). Add 3 to each BCD nibble >=5 before each shift.
  - Result is 4 BCD nibbles (thousands..ones).
  - Then clear byte index to 0 and go to SEND.
- SEND:
  - Load tx_data = byte[idx] and pulse tx_start=1 for exactly one cycle, then go to WAIT_HI.
  - byte[0..3] = 8'h30 + digit (thousands first). byte[4]=8'h0D and byte[5]=8'h0A when SEND_CRLF=1.
  - With CNT_W=14, first tx_start is high during the cycle after edge E15.
- WAIT_HI:
  - Wait for tx_busy=1. The UART TX raises busy within 2 clocks of tx_start.
  - tx_start stays 0; no timeout.
- WAIT_LO:
  - Wait for tx_busy=0 (frame ended).
  - Then, if idx = last (5, or 3 when SEND_CRLF=0): go to DONE.
  - Otherwise: idx+1, back to SEND.
- DONE: done=1 for one cycle, busy=0 on the same edge, return to IDLE. A new send_req is accepted on the next edge.
- Inter-byte gap: tx_start for byte n+1 is asserted on the clock after tx_busy falls for byte n. Exactly one tx_start per byte, never while tx_busy=1.
- Boundary conditions:
  - count_in=0 gives "0000"; 9999 gives "9999"; any value >9999 gives "9999".
  - tx_busy already high when SEND is entered: WAIT_HI passes immediately, then the block waits for the fall.
  - rst mid-record: all state cleared immediately. The UART TX is reset by the same rst, so no partial-record resume.
  - send_req held high continuously: a new record starts on the edge after DONE (back-to-back records).

Test Plan:
- count_in=1234, send_req pulse, bench UART model (busy high 2 clks after start, frame of 160 b_ticks) -> tx_data sequence 0x31,0x32,0x33,0x34,0x0D,0x0A. Exactly 6 tx_start pulses, first tx_start 15 clks after the send_req edge. done pulses once after the last busy fall; busy then low.
- count_in=0, then count_in=9999 -> "0000\r\n" then "9999\r\n"; count_in=12000 -> "9999\r\n" (saturation).
- send_req re-pulsed during byte 2 with count_in=5678 -> ignored; record stays "1234\r\n"; no extra tx_start.
- tx_busy held high 500 clks on byte 0 -> tx_data stays 0x31, no further tx_start, next byte starts 1 clk after the fall.
- rst asserted during WAIT_LO of byte 3 -> tx_start=0, busy=0, done=0, tx_data=0x00 asynchronously. A subsequent send_req with 42 gives "0042\r\n".
- SEND_CRLF=0, count_in=7 -> 4 bytes 0x30,0x30,0x30,0x37, then done.
